// File: rtl/seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg7_scan_decoder
//
// Receive side of a multiplexed 7-segment bus. The segment and anode lines
// come from the display driver and are asynchronous to clock. This block
// synchronises them and waits for each digit pattern to hold steady. It then
// decodes the pattern back into a hex nibble for that digit. It is used as a
// loopback checker for the display path.
//
// Optional feature macro: SEG7_DP_EN
//   When defined, the block adds input dp and output dp_flags. The decimal
//   point is synchronised together with segments and takes part in the
//   stability compare. On accept it is recorded as dp_flags[idx] = ~dp.
//
// Parameters
//   N_DIGITS       digits on the bus (1..8); anodos bits above it are ignored
//   STABLE_CYCLES  identical consecutive synced samples to accept (>= 2)
//   FRAME_TIMEOUT  cycles without an accept before stale is raised
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-low reset
//   segments     in   {CA,CB,CC,CD,CE,CF,CG}, active-low, asynchronous
//   anodos       in   {AN7..AN0}, active-low, asynchronous
//   dp           in   decimal point, active-low (SEG7_DP_EN only)
//   digits       out  nibble i at digits[4*i+3:4*i]
//   digit_valid  out  bit i: nibble i holds a legal decoded value
//   dp_flags     out  bit i: digit i was accepted with its dp lit (SEG7_DP_EN only)
//   frame_done   out  pulse: every digit captured since the previous pulse
//   err_pattern  out  pulse: accepted pattern is neither legal nor blank
//   err_anode    out  pulse: more than one anode active in a synced sample
//   stale        out  pulse: FRAME_TIMEOUT cycles passed without an accept
// ---------------------------------------------------------------------------
module seg7_scan_decoder #(
  parameter int N_DIGITS      = 8,
  parameter int STABLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [6:0]          segments,
  input  logic [7:0]          anodos,
`ifdef SEG7_DP_EN
  input  logic                dp,
  output logic [N_DIGITS-1:0] dp_flags,
`endif
  output logic [31:0]         digits,
  output logic [7:0]          digit_valid,
  output logic                frame_done,
  output logic                err_pattern,
  output logic                err_anode,
  output logic                stale
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(FRAME_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_MAX    = TO_W'(FRAME_TIMEOUT);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(FRAME_TIMEOUT - 1);
  localparam logic [N_DIGITS-1:0] MASK_FULL = '1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] TRACK    = 2'd1;
  localparam logic [1:0] CAPTURED = 2'd2;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // -------------------------------------------------------------------------
  // Two-flop synchronisers
  // -------------------------------------------------------------------------
  logic [6:0] seg_meta, seg_sync;
  logic [7:0] an_meta, an_sync;
`ifdef SEG7_DP_EN
  logic       dp_meta, dp_sync;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      // NOTE: the synchronisers reset to all-ones (inactive bus), not zero.
      // With zeros, the first sample after reset would look like all anodes
      // on at once.
      seg_meta <= '1;
      seg_sync <= '1;
      an_meta  <= '1;
      an_sync  <= '1;
`ifdef SEG7_DP_EN
      dp_meta  <= 1'b1;
      dp_sync  <= 1'b1;
`endif
    end else begin
      // NOTE: non-blocking assignments keep this a true two-stage pipeline.
      // Blocking assignments would collapse it into a single flop.
      seg_meta <= segments;
      seg_sync <= seg_meta;
      an_meta  <= anodos;
      an_sync  <= an_meta;
`ifdef SEG7_DP_EN
      dp_meta  <= dp;
      dp_sync  <= dp_meta;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Anode qualification: count active (zero) anodes in the used range
  // -------------------------------------------------------------------------
  logic [3:0] zero_cnt;
  logic [2:0] an_idx;
  logic       an_valid, an_blank, an_multi;

  always_comb begin
    // NOTE: both outputs get a default before the loop. Otherwise they would
    // be latched whenever no anode is low.
    zero_cnt = 4'd0;
    an_idx   = 3'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!an_sync[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        an_idx   = 3'(i);
      end
    end
  end

  assign an_valid = (zero_cnt == 4'd1);
  assign an_blank = (zero_cnt == 4'd0);
  assign an_multi = (zero_cnt > 4'd1);

  // -------------------------------------------------------------------------
  // Tracking state
  // -------------------------------------------------------------------------
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx_q;
  logic [6:0]       seg_q;
`ifdef SEG7_DP_EN
  logic             dp_q;
`endif
  logic [N_DIGITS-1:0] mask;
  logic [N_DIGITS-1:0] mask_next;
  logic [TO_W-1:0]     to_cnt;

  logic same_digit;
  logic accept;

`ifdef SEG7_DP_EN
  assign same_digit = (an_idx == idx_q) && (seg_sync == seg_q) && (dp_sync == dp_q);
`else
  assign same_digit = (an_idx == idx_q) && (seg_sync == seg_q);
`endif

  // The digit is accepted on the sample that brings the run to STABLE_CYCLES.
  assign accept    = an_valid && (state == TRACK) && same_digit && (cnt == CNT_LAST);
  assign mask_next = mask | (N_DIGITS'(1) << idx_q);

  // Decode an active-low pattern into {legal, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0000001: decode = 5'h10;
      7'b1001111: decode = 5'h11;
      7'b0010010: decode = 5'h12;
      7'b0000110: decode = 5'h13;
      7'b1001100: decode = 5'h14;
      7'b0100100: decode = 5'h15;
      7'b0100000: decode = 5'h16;
      7'b0001111: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0000100: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b1100000: decode = 5'h1B;
      7'b0110001: decode = 5'h1C;
      7'b1000010: decode = 5'h1D;
      7'b0110000: decode = 5'h1E;
      7'b0111000: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction

  logic [4:0] dec;
  assign dec = decode(seg_q);

  // -------------------------------------------------------------------------
  // FSM and capture datapath
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      idx_q       <= '0;
      seg_q       <= '1;
      mask        <= '0;
      to_cnt      <= '0;
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      stale       <= 1'b0;
`ifdef SEG7_DP_EN
      dp_q        <= 1'b1;
      dp_flags    <= '0;
`endif
    end else begin
      frame_done  <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
      stale       <= 1'b0;

      // Sequencing. A change of digit in TRACK or CAPTURED reloads at once,
      // as if the block were starting from IDLE.
      if (an_multi) begin
        err_anode <= 1'b1;
        cnt       <= '0;
        state     <= IDLE;
      end else if (an_blank) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (accept) begin
        cnt   <= cnt + 1'b1;
        state <= CAPTURED;
      end else if (state == IDLE || !same_digit) begin
        idx_q <= an_idx;
        seg_q <= seg_sync;
`ifdef SEG7_DP_EN
        dp_q  <= dp_sync;
`endif
        cnt   <= CNT_W'(1);
        state <= TRACK;
      end else if (state == TRACK) begin
        cnt <= cnt + 1'b1;
      end

      // Capture, frame tracking, and timeout. When both happen in one cycle,
      // the accept wins over the timeout.
      if (accept) begin
        if (dec[4]) begin
          digits[{idx_q, 2'b00} +: 4] <= dec[3:0];
          digit_valid[idx_q]          <= 1'b1;
        end else begin
          digit_valid[idx_q] <= 1'b0;
          if (seg_q != SEG_BLANK) err_pattern <= 1'b1;
        end
`ifdef SEG7_DP_EN
        dp_flags[idx_q] <= ~dp_q;
`endif
        if (mask_next == MASK_FULL) begin
          frame_done <= 1'b1;
          mask       <= '0;
        end else begin
          mask <= mask_next;
        end
        to_cnt <= '0;
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + 1'b1;
        if (to_cnt == TO_LAST) begin
          stale       <= 1'b1;
          digit_valid <= '0;
          mask        <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed stimulus for seg7_scan_decoder. A behavioural model runs beside
// the DUT. It delays the bus by two samples and tracks run lengths of
// identical digit samples. It then applies the decode table, the frame mask,
// and the timeout rules. A compare process checks every output against the
// model on each falling edge. Hand-computed literal checks pin the model at
// key points of each scenario.
// ---------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int N  = 8;
  localparam int S  = 16;
  localparam int TO = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  segments;
  logic [7:0]  anodos;
  logic        dp_drv;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic        frame_done, err_pattern, err_anode, stale;
`ifdef SEG7_DP_EN
  logic [N-1:0] dp_flags;
`endif

  always #5 clock = ~clock;

  seg7_scan_decoder #(
    .N_DIGITS(N), .STABLE_CYCLES(S), .FRAME_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .segments(segments),
    .anodos(anodos),
`ifdef SEG7_DP_EN
    .dp(dp_drv),
    .dp_flags(dp_flags),
`endif
    .digits(digits),
    .digit_valid(digit_valid),
    .frame_done(frame_done),
    .err_pattern(err_pattern),
    .err_anode(err_anode),
    .stale(stale)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Active-low patterns for hex digits 0..F, in {CA..CG} order.
  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // -------------------------------------------------------------------------
  // Behavioural model
  // -------------------------------------------------------------------------
  logic [15:0] hist [$];          // {dp, seg[6:0], an[7:0]} bus samples
  bit          model_on = 1'b0;
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_mask, m_dpf;
  logic        m_frame, m_errp, m_erra, m_stale;
  int          m_to, run_len, run_idx;
  logic [7:0]  run_seg;

  always @(posedge clock) begin : model
    logic [15:0] smp;
    int          zeros, idx, nib;
    bit          found;
    if (!reset) begin
      hist     = '{16'hFFFF, 16'hFFFF};
      m_digits = '0; m_valid = '0; m_mask = '0; m_dpf = '0;
      m_frame  = 0; m_errp = 0; m_erra = 0; m_stale = 0;
      m_to     = 0; run_len = 0; run_idx = 0; run_seg = '1;
      model_on = 1'b1;
    end else if (model_on) begin
      smp = hist.pop_front();
      hist.push_back({dp_drv, segments, anodos});
      m_frame = 0; m_errp = 0; m_erra = 0; m_stale = 0;
      zeros = 0; idx = 0;
      for (int i = 0; i < N; i++) if (!smp[i]) begin zeros++; idx = i; end
      if (zeros > 1) begin
        m_erra  = 1;
        run_len = 0;
      end else if (zeros == 0) begin
        run_len = 0;
      end else if (run_len > 0 && idx == run_idx && smp[15:8] == run_seg) begin
        run_len++;
      end else begin
        run_len = 1; run_idx = idx; run_seg = smp[15:8];
      end
      if (zeros == 1 && run_len == S) begin
        found = 0; nib = 0;
        for (int k = 0; k < 16; k++) if (seg_tab[k] == run_seg[6:0]) begin found = 1; nib = k; end
        if (found) begin
          m_digits[4*run_idx +: 4] = nib[3:0];
          m_valid[run_idx] = 1'b1;
        end else begin
          m_valid[run_idx] = 1'b0;
          if (run_seg[6:0] != 7'h7F) m_errp = 1;
        end
        m_dpf[run_idx]  = ~run_seg[7];
        m_mask[run_idx] = 1'b1;
        if (m_mask == 8'hFF) begin m_frame = 1; m_mask = '0; end
        m_to = 0;
      end else if (m_to < TO) begin
        m_to++;
        if (m_to == TO) begin m_stale = 1; m_valid = '0; m_mask = '0; end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Per-cycle compare and pulse counting
  // -------------------------------------------------------------------------
  int n_frame = 0, n_errp = 0, n_erra = 0, n_stale = 0;

  always @(negedge clock) begin
    if (model_on) begin
      check("digits",      digits,      m_digits);
      check("digit_valid", {24'd0, digit_valid}, {24'd0, m_valid});
      check("frame_done",  {31'd0, frame_done},  {31'd0, m_frame});
      check("err_pattern", {31'd0, err_pattern}, {31'd0, m_errp});
      check("err_anode",   {31'd0, err_anode},   {31'd0, m_erra});
      check("stale",       {31'd0, stale},       {31'd0, m_stale});
`ifdef SEG7_DP_EN
      check("dp_flags",    {24'd0, dp_flags},    {24'd0, m_dpf});
`endif
      n_frame += int'(frame_done);
      n_errp  += int'(err_pattern);
      n_erra  += int'(err_anode);
      n_stale += int'(stale);
    end
  end

  // -------------------------------------------------------------------------
  // Directed stimulus with literal expectations
  // -------------------------------------------------------------------------
  task automatic hold(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive(input logic [7:0] an, input logic [6:0] seg);
    anodos   = an;
    segments = seg;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c0, c1;
    reset = 1'b0; dp_drv = 1'b1;
    drive(8'hFF, 7'h7F);
    hold(3);
    check("reset_digits", digits, 32'h0);
    check("reset_valid",  {24'd0, digit_valid}, 32'h0);
    reset = 1'b1;
    hold(2);

    // 1: single digit settles after 2+S clocks
    c0 = n_errp;
    drive(8'hFE, 7'b0010010);
    hold(S + 1);
    check("t1_not_yet_valid", {24'd0, digit_valid}, 32'h0);
    hold(1);
    check("t1_nibble", {28'd0, digits[3:0]}, 32'h2);
    check("t1_valid",  {24'd0, digit_valid}, 32'h01);
    hold(2);
    check("t1_no_err", n_errp - c0, 0);

    // 2: full scan 0..7
    c0 = n_frame;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_tab[d]);
      hold(32);
    end
    check("t2_digits", digits, 32'h76543210);
    check("t2_valid",  {24'd0, digit_valid}, 32'hFF);
    check("t2_frames", n_frame - c0, 1);

    // 3: unstable pattern is never accepted, then settles
    for (int p = 0; p < 8; p++) begin
      drive(8'hFB, seg_tab[3 + (p % 2)]);
      hold(5);
    end
    check("t3_unchanged_nibble", {28'd0, digits[11:8]}, 32'h2);
    check("t3_unchanged_valid",  {31'd0, digit_valid[2]}, 32'h1);
    hold(20);
    check("t3_accept", {28'd0, digits[11:8]}, 32'h4);

    // 4: two anodes active, then an illegal pattern
    c0 = n_erra;
    c1 = n_errp;
    drive(8'hFC, seg_tab[5]);
    hold(10);
    drive(8'hFE, 7'b1111110);
    hold(20);
    check("t4_err_anode_cnt", n_erra - c0, 10);
    check("t4_err_pattern",   n_errp - c1, 1);
    check("t4_digits",        digits, 32'h76543410);
    check("t4_valid",         {24'd0, digit_valid}, 32'hFE);

    // 5: full frame, then idle bus until stale, then reset mid-track
    c0 = n_frame;
    for (int d = 0; d < 8; d++) begin
      drive(~(8'h01 << d), seg_tab[8 + d]);
      hold(32);
    end
    check("t5_digits", digits, 32'hFEDCBA98);
    check("t5_valid",  {24'd0, digit_valid}, 32'hFF);
    check("t5_frames", n_frame - c0, 1);
    c1 = n_stale;
    drive(8'hFF, 7'h7F);
    hold(80);
    check("t5_no_stale_yet", n_stale - c1, 0);
    check("t5_valid_kept",   {24'd0, digit_valid}, 32'hFF);
    hold(50);
    check("t5_one_stale",      n_stale - c1, 1);
    check("t5_valid_cleared",  {24'd0, digit_valid}, 32'h0);
    drive(8'hFE, seg_tab[5]);
    hold(8);
    reset = 1'b0;
    hold(1);
    check("t5_rst_digits", digits, 32'h0);
    check("t5_rst_valid",  {24'd0, digit_valid}, 32'h0);
    check("t5_rst_pulses", {28'd0, frame_done, err_pattern, err_anode, stale}, 32'h0);
    reset = 1'b1;
    hold(S + 2);
    check("t5_post_rst_nibble", {28'd0, digits[3:0]}, 32'h5);
    check("t5_post_rst_valid",  {24'd0, digit_valid}, 32'h01);

`ifdef SEG7_DP_EN
    // 6: decimal point captured alongside digit 3
    drive(8'hF7, seg_tab[9]);
    dp_drv = 1'b0;
    hold(20);
    check("t6_nibble", {28'd0, digits[15:12]}, 32'h9);
    check("t6_dp",     {31'd0, dp_flags[3]}, 32'h1);
    dp_drv = 1'b1;
    hold(4);
`endif

    hold(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
